// File: rtl/airi5c_prebuf_q.sv
// rtl/airi5c_prebuf_q.sv - instruction prefetch halfword queue with 16/32-bit instruction framing
//
// Purpose: buffers 32-bit fetch words as a circular stream of halfwords and
// presents a 32-bit instruction window starting at the oldest halfword, with
// compressed (16-bit) and full (32-bit) instruction length decoding.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   flush_i          synchronous clear of queue contents (priority over push/pop)
//   flush_misalign_i with flush_i: drop low halfword of first word pushed after flush
//   push_valid_i     fetch word offered
//   push_data_i      fetch word, [15:0] precedes [31:16] in program order
//   push_ready_o     queue can accept a word this cycle
//   instr_o          instruction window at the oldest stored halfword
//   instr_valid_o    instr_o holds a complete instruction
//   pop_i            consumer takes the instruction on instr_o
//   level_o          number of stored halfwords
module airi5c_prebuf_q #(
    parameter int DEPTH    = 4,
    parameter int HW_CNT_W = $clog2(2*DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                flush_misalign_i,
    input  logic                push_valid_i,
    input  logic [31:0]         push_data_i,
    output logic                push_ready_o,
    output logic [31:0]         instr_o,
    output logic                instr_valid_o,
    input  logic                pop_i,
    output logic [HW_CNT_W-1:0] level_o
);

    localparam int NHW   = 2 * DEPTH;
    localparam int PTR_W = $clog2(NHW);

    // Halfword storage is deliberately not reset; every output is qualified by count.
    logic [15:0]         hw_q [NHW];

    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [HW_CNT_W-1:0] count_q, count_d;
    logic                mis_q, mis_d;

    logic [PTR_W-1:0]    rptr_inc, wptr_inc;
    logic [15:0]         lo_hw, hi_hw;
    logic                is_16b;
    logic                push_acc, pop_acc;
    logic                wr0_en, wr1_en;
    logic [15:0]         wr0_data, wr1_data;
    logic [HW_CNT_W-1:0] push_n, pop_n;

    assign rptr_inc = rptr_q + PTR_W'(1);
    assign wptr_inc = wptr_q + PTR_W'(1);

    // Window is built from registered state only, so push_data_i never reaches instr_o.
    assign lo_hw  = (count_q >= HW_CNT_W'(1)) ? hw_q[rptr_q]   : 16'h0;
    assign hi_hw  = (count_q >= HW_CNT_W'(2)) ? hw_q[rptr_inc] : 16'h0;
    assign is_16b = (lo_hw[1:0] != 2'b11);

    assign instr_o       = {hi_hw, lo_hw};
    assign instr_valid_o = (count_q >= HW_CNT_W'(1) && is_16b) ||
                           (count_q >= HW_CNT_W'(2) && !is_16b);
    // Two free halfword slots needed; independent of pop_i in the same cycle.
    assign push_ready_o  = (count_q <= HW_CNT_W'(NHW - 2));
    assign level_o       = count_q;

    assign push_acc = push_valid_i && push_ready_o && !flush_i;
    assign pop_acc  = pop_i && instr_valid_o && !flush_i;

    always_comb begin
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = push_data_i[15:0];
        wr1_data = push_data_i[31:16];
        push_n   = '0;
        pop_n    = '0;
        rptr_d   = rptr_q;
        wptr_d   = wptr_q;
        count_d  = count_q;
        mis_d    = mis_q;

        if (push_acc) begin
            if (mis_q) begin
                // Misaligned restart: only the upper halfword belongs to the stream.
                wr0_en   = 1'b1;
                wr0_data = push_data_i[31:16];
                push_n   = HW_CNT_W'(1);
                wptr_d   = wptr_q + PTR_W'(1);
                mis_d    = 1'b0;
            end else begin
                wr0_en   = 1'b1;
                wr1_en   = 1'b1;
                push_n   = HW_CNT_W'(2);
                wptr_d   = wptr_q + PTR_W'(2);
            end
        end

        if (pop_acc) begin
            pop_n  = is_16b ? HW_CNT_W'(1) : HW_CNT_W'(2);
            rptr_d = rptr_q + (is_16b ? PTR_W'(1) : PTR_W'(2));
        end

        count_d = count_q + push_n - pop_n;

        if (flush_i) begin
            wr0_en  = 1'b0;
            wr1_en  = 1'b0;
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
            mis_d   = flush_misalign_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            mis_q   <= mis_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr0_en) hw_q[wptr_q]   <= wr0_data;
        if (wr1_en) hw_q[wptr_inc] <= wr1_data;
    end

endmodule

// File: tb/tb_airi5c_prebuf_q.sv
// tb/tb_airi5c_prebuf_q.sv - self-checking bench for airi5c_prebuf_q
module tb_airi5c_prebuf_q;

    localparam int DEPTH = 4;
    localparam int HW_CNT_W = $clog2(2*DEPTH) + 1;
    localparam int NVEC = 23;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                flush_i, flush_misalign_i, push_valid_i, pop_i;
    logic [31:0]         push_data_i;
    logic                push_ready_o, instr_valid_o;
    logic [31:0]         instr_o;
    logic [HW_CNT_W-1:0] level_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    airi5c_prebuf_q #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .flush_misalign_i (flush_misalign_i),
        .push_valid_i     (push_valid_i),
        .push_data_i      (push_data_i),
        .push_ready_o     (push_ready_o),
        .instr_o          (instr_o),
        .instr_valid_o    (instr_valid_o),
        .pop_i            (pop_i),
        .level_o          (level_o)
    );

    typedef struct {
        logic        fl;
        logic        mis;
        logic        pv;
        logic [31:0] pd;
        logic        pop;
        logic        rdy;
        logic        vld;
        logic [31:0] ins;
        logic [3:0]  lvl;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic mis, input logic pv,
                         input logic [31:0] pd, input logic pp);
        flush_i          = fl;
        flush_misalign_i = mis;
        push_valid_i     = pv;
        push_data_i      = pd;
        pop_i            = pp;
    endtask

    // Reference model: plain halfword stream in program order.
    logic [15:0] hq[$];
    logic        m_mis;

    function automatic logic m_valid();
        if (hq.size() == 0) return 1'b0;
        if (hq[0][1:0] != 2'b11) return 1'b1;
        return hq.size() >= 2;
    endfunction

    initial begin
        drive(0, 0, 0, 32'h0, 0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_ready", {31'b0, push_ready_o}, 32'd1);
        chk("reset_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("reset_instr", instr_o, 32'h0);
        chk("reset_level", 32'(level_o), 32'd0);
        rst_ni = 1'b1;

        //          fl mis pv data          pop  rdy vld instr         lvl
        vecs[0]  = '{0, 0, 1, 32'h0013_0001, 0,  1, 1, 32'h0013_0001, 2};
        vecs[1]  = '{0, 0, 0, 32'h0,         1,  1, 0, 32'h0000_0013, 1};
        vecs[2]  = '{0, 0, 1, 32'h5555_ABCD, 0,  1, 1, 32'hABCD_0013, 3};
        vecs[3]  = '{0, 0, 0, 32'h0,         1,  1, 1, 32'h0000_5555, 1};
        vecs[4]  = '{0, 0, 0, 32'h0,         1,  1, 0, 32'h0000_0000, 0};
        vecs[5]  = '{0, 0, 0, 32'h0,         1,  1, 0, 32'h0000_0000, 0};
        vecs[6]  = '{0, 0, 1, 32'h0002_0003, 0,  1, 1, 32'h0002_0003, 2};
        vecs[7]  = '{0, 0, 0, 32'h0,         1,  1, 0, 32'h0000_0000, 0};
        vecs[8]  = '{0, 0, 1, 32'h0011_0021, 0,  1, 1, 32'h0011_0021, 2};
        vecs[9]  = '{0, 0, 1, 32'h0033_0043, 0,  1, 1, 32'h0011_0021, 4};
        vecs[10] = '{0, 0, 1, 32'h0005_0007, 0,  1, 1, 32'h0011_0021, 6};
        vecs[11] = '{0, 0, 1, 32'h0009_000B, 0,  0, 1, 32'h0011_0021, 8};
        vecs[12] = '{0, 0, 1, 32'hDEAD_BEEF, 0,  0, 1, 32'h0011_0021, 8};
        vecs[13] = '{0, 0, 0, 32'h0,         1,  0, 1, 32'h0043_0011, 7};
        vecs[14] = '{0, 0, 0, 32'h0,         1,  1, 1, 32'h0033_0043, 6};
        vecs[15] = '{0, 0, 1, 32'h0101_0202, 1,  1, 1, 32'h0005_0007, 6};
        vecs[16] = '{1, 0, 1, 32'h1234_5678, 1,  1, 0, 32'h0000_0000, 0};
        vecs[17] = '{1, 1, 0, 32'h0,         0,  1, 0, 32'h0000_0000, 0};
        vecs[18] = '{0, 0, 1, 32'hABCD_0001, 0,  1, 1, 32'h0000_ABCD, 1};
        vecs[19] = '{0, 0, 1, 32'h2222_0003, 0,  1, 1, 32'h0003_ABCD, 3};
        vecs[20] = '{1, 1, 0, 32'h0,         0,  1, 0, 32'h0000_0000, 0};
        vecs[21] = '{0, 0, 1, 32'h0003_1111, 0,  1, 0, 32'h0000_0003, 1};
        vecs[22] = '{0, 0, 1, 32'h0004_0008, 0,  1, 1, 32'h0008_0003, 3};

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].fl, vecs[i].mis, vecs[i].pv, vecs[i].pd, vecs[i].pop);
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, push_ready_o}, {31'b0, vecs[i].rdy});
            chk($sformatf("v%0d_valid", i), {31'b0, instr_valid_o}, {31'b0, vecs[i].vld});
            chk($sformatf("v%0d_level", i), 32'(level_o), 32'(vecs[i].lvl));
            if (vecs[i].vld || vecs[i].lvl != 0)
                chk($sformatf("v%0d_instr", i), instr_o, vecs[i].ins);
        end

        // Reset released with a push already offered: first edge accepts it.
        drive(0, 0, 1, 32'h0000_0001, 0);
        rst_ni = 1'b0;
        #2;
        chk("rst_async_level", 32'(level_o), 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_release_push", 32'(level_o), 32'd2);

        // Random push/pop against the halfword-stream model.
        drive(1, 0, 0, 32'h0, 0);
        @(posedge clk_i);
        #1;
        hq.delete();
        m_mis = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            logic        fl, mis, pv, pp, m_rdy, m_vld;
            logic [31:0] pd, m_ins;
            m_rdy = (hq.size() <= 2*DEPTH - 2);
            m_vld = m_valid();
            m_ins = {(hq.size() >= 2) ? hq[1] : 16'h0, (hq.size() >= 1) ? hq[0] : 16'h0};
            chk("rnd_ready", {31'b0, push_ready_o}, {31'b0, m_rdy});
            chk("rnd_valid", {31'b0, instr_valid_o}, {31'b0, m_vld});
            chk("rnd_level", 32'(level_o), 32'(hq.size()));
            if (m_vld) chk("rnd_instr", instr_o, m_ins);

            fl  = ($urandom_range(0, 99) < 3);
            mis = $urandom_range(0, 1) == 1;
            pv  = ($urandom_range(0, 99) < 60);
            pp  = ($urandom_range(0, 99) < 60);
            pd  = $urandom;
            drive(fl, mis, pv, pd, pp);
            @(posedge clk_i);
            #1;
            if (fl) begin
                hq.delete();
                m_mis = mis;
            end else begin
                if (pp && m_vld) begin
                    if (hq[0][1:0] != 2'b11) void'(hq.pop_front());
                    else begin
                        void'(hq.pop_front());
                        void'(hq.pop_front());
                    end
                end
                if (pv && m_rdy) begin
                    if (m_mis) begin
                        hq.push_back(pd[31:16]);
                        m_mis = 1'b0;
                    end else begin
                        hq.push_back(pd[15:0]);
                        hq.push_back(pd[31:16]);
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
